// File: rtl/fxp8s_pe_ctrl_if.sv
// Bundle of the control, operand-stream, result-stream and PE-row signals
// of the fxp8s PE sequencer.
//   master : the sequencer side (drives busy/done/s_ready/res_*/pe_* outputs)
//   slave  : the environment side (job source, operand source, result sink, PE row)
// Ports:
//   start, cfg_len        job request and column count K
//   busy, done            job status
//   s_valid/s_ready/s_data        operand stream (fxp8s, 2's complement)
//   res_valid/res_ready/res_data  result stream (one word per PE, PE 0 first)
//   pe_rstn, pe_in_row, pe_en_in, pe_in_data  PE row input side
//   pe_en_out, pe_out_data                    shared PE result bus
interface fxp8s_pe_ctrl_if #(
  parameter int N     = 4,
  parameter int LEN_W = 8
);
  logic                    start;
  logic [LEN_W-1:0]        cfg_len;
  logic                    busy;
  logic                    done;
  logic                    s_valid;
  logic                    s_ready;
  logic signed [7:0]       s_data;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [7:0]       res_data;
  logic                    pe_rstn;
  logic                    pe_in_row;
  logic [N-1:0]            pe_en_in;
  logic signed [7:0]       pe_in_data;
  logic [N-1:0]            pe_en_out;
  logic signed [7:0]       pe_out_data;

  modport master (
    input  start, cfg_len, s_valid, s_data, res_ready, pe_out_data,
    output busy, done, s_ready, res_valid, res_data,
           pe_rstn, pe_in_row, pe_en_in, pe_in_data, pe_en_out
  );

  modport slave (
    output start, cfg_len, s_valid, s_data, res_ready, pe_out_data,
    input  busy, done, s_ready, res_valid, res_data,
           pe_rstn, pe_in_row, pe_en_in, pe_in_data, pe_en_out
  );
endinterface

// File: rtl/fxp8s_pe_ctrl.sv
// Sequencer for a row of N fxp8s processing elements sharing one result bus.
// A job clears the PEs, loads DEPTH operand words into each PE (PE 0 first),
// broadcasts K column operands, waits out the PE pipeline and then reads each
// PE accumulator over the shared bus onto the result stream.
// Ports:
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   fxp8s_pe_ctrl_if.master (job control, operand stream, result
//         stream, PE row control and shared PE result bus)
module fxp8s_pe_ctrl #(
  parameter int N       = 4,
  parameter int DEPTH   = 3,
  parameter int MUL_LAT = 1,
  parameter int LEN_W   = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  fxp8s_pe_ctrl_if.master        bus
);
  localparam int PE_W = (N > 1) ? $clog2(N) : 1;
  localparam int WC_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DRN  = MUL_LAT + 2;  // input register + multiplier + accumulator
  localparam int DR_W = $clog2(DRN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LOAD, S_STREAM, S_DRAIN, S_RD_DRV, S_RD_WAIT, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PE_W-1:0]    r_pe_idx;
  logic [PE_W-1:0]    r_rd_idx;
  logic [PE_W-1:0]    w_rd_nxt;
  logic [WC_W-1:0]    r_word_cnt;
  logic [LEN_W-1:0]   r_k;
  logic [LEN_W-1:0]   r_col_cnt;
  logic [DR_W-1:0]    r_drn_cnt;
  logic               r_busy;
  logic               r_done;
  logic               r_s_ready;
  logic               r_in_row;
  logic               r_res_valid;
  logic signed [7:0]  r_res_data;
  logic [N-1:0]       r_en_out;
  logic               w_hs;
  logic               w_last_row;
  logic [N-1:0]       w_row_sel;

  assign w_hs       = bus.s_valid & r_s_ready;
  assign w_last_row = (r_pe_idx == PE_W'(N - 1)) && (r_word_cnt == WC_W'(DEPTH - 1));
  assign w_row_sel  = N'(1) << r_pe_idx;

  // PE input side follows the handshake combinationally, so each accepted
  // word produces exactly one enable pulse and a gap produces none.
  assign bus.pe_rstn    = rstn & (r_state != S_CLR);
  assign bus.pe_in_row  = r_in_row;
  assign bus.pe_en_in   = !w_hs ? '0 : ((r_state == S_LOAD) ? w_row_sel : '1);
  assign bus.pe_in_data = w_hs ? bus.s_data : '0;
  assign bus.pe_en_out  = r_en_out;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.s_ready    = r_s_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd_idx;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = S_CLR;
      S_CLR:    w_state_nxt = S_LOAD;
      S_LOAD:   if (w_hs && w_last_row) w_state_nxt = (r_k != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (w_hs && (r_col_cnt == r_k - LEN_W'(1))) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (r_drn_cnt == DR_W'(DRN - 1)) begin
          w_state_nxt = S_RD_DRV;
          w_rd_nxt    = '0;
        end
      end
      S_RD_DRV: w_state_nxt = S_RD_WAIT;
      // res_valid is always high in RD_WAIT, so res_ready alone is the handshake.
      S_RD_WAIT: begin
        if (bus.res_ready) begin
          if (r_rd_idx == PE_W'(N - 1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RD_DRV;
            w_rd_nxt    = r_rd_idx + PE_W'(1);
          end
        end
      end
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_in_row    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_en_out    <= '0;
      r_rd_idx    <= '0;
      r_pe_idx    <= '0;
      r_word_cnt  <= '0;
      r_k         <= '0;
      r_col_cnt   <= '0;
      r_drn_cnt   <= '0;
    end else begin
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_DONE);
      r_s_ready <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_STREAM);
      r_in_row  <= (w_state_nxt == S_LOAD);
      r_rd_idx  <= w_rd_nxt;
      r_en_out  <= (w_state_nxt == S_RD_DRV) ? (N'(1) << w_rd_nxt) : '0;

      if ((r_state == S_IDLE) && bus.start) r_k <= bus.cfg_len;

      if (r_state == S_CLR) begin
        r_pe_idx   <= '0;
        r_word_cnt <= '0;
        r_col_cnt  <= '0;
        r_drn_cnt  <= '0;
      end

      if ((r_state == S_LOAD) && w_hs) begin
        if (r_word_cnt == WC_W'(DEPTH - 1)) begin
          r_word_cnt <= '0;
          r_pe_idx   <= r_pe_idx + PE_W'(1);
        end else begin
          r_word_cnt <= r_word_cnt + WC_W'(1);
        end
      end

      if ((r_state == S_STREAM) && w_hs) r_col_cnt <= r_col_cnt + LEN_W'(1);
      if (r_state == S_DRAIN)            r_drn_cnt <= r_drn_cnt + DR_W'(1);

      // The selected PE drives the bus during RD_DRV; capture it at the end
      // of that cycle and hold until the consumer takes it.
      if (r_state == S_RD_DRV) begin
        r_res_data  <= bus.pe_out_data;
        r_res_valid <= 1'b1;
      end else if ((r_state == S_RD_WAIT) && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fxp8s_pe_ctrl.sv
module tb_fxp8s_pe_ctrl;
  localparam int N       = 4;
  localparam int DEPTH   = 3;
  localparam int MUL_LAT = 1;
  localparam int LEN_W   = 8;
  localparam int P       = MUL_LAT + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int total = 0;
  int bad = 0;
  int n_hs = 0;
  int n_done = 0;
  int n_viol = 0;

  always #5 clk = ~clk;

  fxp8s_pe_ctrl_if #(.N(N), .LEN_W(LEN_W)) bus ();

  fxp8s_pe_ctrl #(.N(N), .DEPTH(DEPTH), .MUL_LAT(MUL_LAT), .LEN_W(LEN_W)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // fxp8s product with 3 fractional bits
  function automatic int mac(input int a, input int b);
    return (a * b) >>> 3;
  endfunction

  // Reference: PE p holds rows[p*DEPTH..], column j multiplies buffer word j%DEPTH.
  task automatic ref_results(input int words[$], input int k, output int exp_q[$]);
    exp_q = {};
    for (int p = 0; p < N; p++) begin
      int acc;
      acc = 0;
      for (int j = 0; j < k; j++)
        acc = sat8(acc + mac(words[p*DEPTH + (j % DEPTH)], words[N*DEPTH + j]));
      exp_q.push_back(acc);
    end
  endtask

  // Behavioural PE row driven by the controller outputs
  int m_acc [N];
  int m_buf [N][DEPTH];
  int m_wp  [N];
  int m_cp  [N];
  int m_pp  [N][P];
  bit m_pv  [N][P];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!bus.pe_rstn) begin
        m_acc[i] <= 0;
        m_wp[i]  <= 0;
        m_cp[i]  <= 0;
        for (int s = 0; s < P; s++) m_pv[i][s] <= 1'b0;
      end else begin
        if (m_pv[i][P-1]) m_acc[i] <= sat8(m_acc[i] + m_pp[i][P-1]);
        for (int s = P - 1; s > 0; s--) begin
          m_pv[i][s] <= m_pv[i][s-1];
          m_pp[i][s] <= m_pp[i][s-1];
        end
        m_pv[i][0] <= 1'b0;
        if (bus.pe_en_in[i]) begin
          if (bus.pe_in_row) begin
            m_buf[i][m_wp[i]] <= int'(bus.pe_in_data);
            m_wp[i] <= (m_wp[i] + 1) % DEPTH;
          end else begin
            m_pv[i][0] <= 1'b1;
            m_pp[i][0] <= mac(m_buf[i][m_cp[i]], int'(bus.pe_in_data));
            m_cp[i] <= (m_cp[i] + 1) % DEPTH;
          end
        end
      end
    end
  end

  always_comb begin
    bus.pe_out_data = 8'sh00;
    for (int i = 0; i < N; i++)
      if (bus.pe_en_out[i]) bus.pe_out_data = m_acc[i][7:0];
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.s_valid && bus.s_ready) n_hs <= n_hs + 1;
      if (bus.done) n_done <= n_done + 1;
      if (($countones(bus.pe_en_out) > 1) ||
          ((bus.pe_en_in != '0) && !(bus.s_valid && bus.s_ready)) ||
          (bus.s_ready && !bus.busy) ||
          ((bus.pe_en_out != '0) && !bus.busy))
        n_viol <= n_viol + 1;
    end
  end

  task automatic feed(input int words[$], input int gap, input int limit,
                      input int pulse_at, input int pulse_len);
    int idx;
    int cyc;
    bit pulsed;
    idx = 0;
    cyc = 0;
    pulsed = 1'b0;
    while (idx < limit && cyc < 4000) begin
      case (gap)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = ((cyc % 2) == 0);
        default: bus.s_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.s_data = 8'(words[idx]);
      if (idx == pulse_at && !pulsed) begin
        bus.start   = 1'b1;
        bus.cfg_len = LEN_W'(pulse_len);
        pulsed      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    if (cyc >= 4000) chk("feed_timeout", idx, limit);
  endtask

  task automatic collect(input int n, input int stall, output int got_q[$]);
    int cyc;
    int hold;
    logic signed [7:0] held;
    cyc = 0;
    hold = 0;
    held = '0;
    got_q = {};
    bus.res_ready = !(stall == 0);
    while (got_q.size() < n && cyc < 4000) begin
      @(negedge clk);
      if (got_q.size() == stall && hold > 0) chk("stall_valid", bus.res_valid, 1);
      if (bus.res_valid && bus.res_ready) begin
        if (got_q.size() == stall && hold > 0) chk("stall_release_data", bus.res_data, held);
        got_q.push_back(int'(bus.res_data));
      end else if (bus.res_valid) begin
        if (hold == 0) held = bus.res_data;
        else chk("stall_hold_data", bus.res_data, held);
        chk("stall_en_out", bus.pe_en_out, 0);
        hold++;
      end
      @(posedge clk); #1;
      bus.res_ready = !(got_q.size() == stall && hold < 10);
      cyc++;
    end
    bus.res_ready = 1'b1;
    if (cyc >= 4000) chk("collect_timeout", got_q.size(), n);
  endtask

  task automatic run_job(input string tag, input int words[$], input int k,
                         input int gap, input int stall, input bit pulse);
    int exp_q[$];
    int got_q[$];
    int hs0, dn0, vi0, cyc;
    ref_results(words, k, exp_q);
    hs0 = n_hs;
    dn0 = n_done;
    vi0 = n_viol;
    bus.start   = 1'b1;
    bus.cfg_len = LEN_W'(k);
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.cfg_len = LEN_W'($urandom);
    chk({tag, "_busy"}, bus.busy, 1);
    fork
      feed(words, gap, N*DEPTH + k, pulse ? N*DEPTH + 1 : -1, k + 3);
      collect(N, stall, got_q);
    join
    for (int p = 0; p < N; p++)
      chk($sformatf("%s_res%0d", tag, p), (p < got_q.size()) ? got_q[p] : 32'hDEAD, exp_q[p]);
    cyc = 0;
    while (bus.busy && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_idle"}, (cyc < 50), 1);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hs"}, n_hs - hs0, N*DEPTH + k);
    chk({tag, "_done"}, n_done - dn0, 1);
    chk({tag, "_viol"}, n_viol - vi0, 0);
  endtask

  task automatic make_words(input int k, output int w[$]);
    w = {};
    for (int i = 0; i < N*DEPTH + k; i++) w.push_back(int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_data"}, bus.res_data, 0);
    chk({tag, "_pe_rstn"}, bus.pe_rstn, 0);
    chk({tag, "_pe_en_in"}, bus.pe_en_in, 0);
    chk({tag, "_pe_en_out"}, bus.pe_en_out, 0);
    chk({tag, "_pe_in_data"}, bus.pe_in_data, 0);
  endtask

  initial begin
    int w[$];
    bus.start     = 1'b0;
    bus.cfg_len   = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.res_ready = 1'b1;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_pe_rstn", bus.pe_rstn, 1);
    chk("rst_rel_busy", bus.busy, 0);

    // directed: PE i rows {1.0*(i+1), 0, 0}, two columns of 1.0
    w = {};
    for (int i = 0; i < N; i++) begin
      w.push_back(8 * (i + 1));
      w.push_back(0);
      w.push_back(0);
    end
    w.push_back(8);
    w.push_back(8);
    run_job("dir", w, 2, 0, -1, 1'b0);

    make_words(0, w);
    run_job("k0", w, 0, 0, -1, 1'b0);

    // reset after 5 of 12 operand words
    make_words(3, w);
    bus.start   = 1'b1;
    bus.cfg_len = LEN_W'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed(w, 0, 5, -1, 0);
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_reset("midrst");
    rstn = 1'b1;
    @(posedge clk); #1;
    run_job("after_rst", w, 3, 0, -1, 1'b0);

    make_words(5, w);
    run_job("nogap", w, 5, 0, -1, 1'b0);
    run_job("toggle", w, 5, 1, -1, 1'b0);

    make_words(4, w);
    run_job("stall", w, 4, 0, 1, 1'b0);

    make_words(4, w);
    run_job("pulse", w, 4, 0, -1, 1'b1);

    make_words(255, w);
    run_job("kmax", w, 255, 2, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      int k;
      k = int'($urandom_range(0, 20));
      make_words(k, w);
      run_job($sformatf("rnd%0d", r), w, k, 2, int'($urandom_range(0, N)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
